// File: rtl/trashbin_bus_pkg.sv
// Shared definitions for the TrashbinCore memory bus: word width, port
// indices and the arbiter state encoding.
package trashbin_bus_pkg;

  localparam int BUS_WIDTH = 32;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_AUX  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arbState_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker. On a tie the port that did not win the last
// tie is chosen; a lone requester always wins.
module rr_arb2 (
  input  logic Req0,
  input  logic Req1,
  input  logic LastGrant,
  output logic GrantIdx,
  output logic GrantValid
);

  // Pick a winner from the current request bits and the last tie winner.
  always_comb begin
    GrantValid = Req0 | Req1;
    GrantIdx   = Req1;
    if (Req0 && Req1) begin
      GrantIdx = ~LastGrant;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single-port word RAM between the core bus (port 0) and an
// auxiliary master (port 1). One transaction at a time, three cycles each:
// IDLE (grant) -> ACCESS (RAM address/write) -> RESP (Ack pulse).
//
// Handshake: a port raises Req with Write/Addr/WData stable and keeps it high
// until its one-cycle Ack. Req is only sampled in IDLE, so a Req that drops
// before being sampled there is simply withdrawn, and a Req still high in the
// cycle after Ack is taken as a fresh request. Once granted, a transaction
// always completes even if Req drops. RData/Err are valid only with Ack.
module mem_bus_arbiter
  import trashbin_bus_pkg::*;
#(
  parameter int                   AddrWidth = 14,
  parameter logic [BUS_WIDTH-1:0] ErrData   = 32'h0000_0000
) (
  input  logic                 CoreClock,
  input  logic                 CoreResetN,
  input  logic                 P0Req,
  input  logic                 P0Write,
  input  logic [BUS_WIDTH-1:0] P0Addr,
  input  logic [BUS_WIDTH-1:0] P0WData,
  output logic                 P0Ack,
  output logic [BUS_WIDTH-1:0] P0RData,
  output logic                 P0Err,
  input  logic                 P1Req,
  input  logic                 P1Write,
  input  logic [BUS_WIDTH-1:0] P1Addr,
  input  logic [BUS_WIDTH-1:0] P1WData,
  output logic                 P1Ack,
  output logic [BUS_WIDTH-1:0] P1RData,
  output logic                 P1Err,
  output logic [AddrWidth-1:0] MemAddr,
  output logic [BUS_WIDTH-1:0] MemWData,
  output logic                 MemWrite,
  input  logic [BUS_WIDTH-1:0] MemRData,
  output logic                 Owner,
  output logic [1:0]           DbgState
);

  arbState_t            state;
  arbState_t            stateNext;
  logic                 lastGrant;
  logic                 ownerQ;
  logic                 curWrite;
  logic                 curErr;
  logic                 grantIdx;
  logic                 grantValid;
  logic                 bothReq;
  logic                 selWrite;
  logic [BUS_WIDTH-1:0] selAddr;
  logic [BUS_WIDTH-1:0] selWData;
  logic                 selOutOfWindow;
  logic                 inResp;
  logic [BUS_WIDTH-1:0] respData;

  rr_arb2 uPick (
    .Req0       (P0Req),
    .Req1       (P1Req),
    .LastGrant  (lastGrant),
    .GrantIdx   (grantIdx),
    .GrantValid (grantValid)
  );

  // Route the winning port's request fields and classify its address.
  always_comb begin
    bothReq        = P0Req & P1Req;
    selWrite       = grantIdx ? P1Write : P0Write;
    selAddr        = grantIdx ? P1Addr  : P0Addr;
    selWData       = grantIdx ? P1WData : P0WData;
    selOutOfWindow = |selAddr[BUS_WIDTH-1:AddrWidth];
  end

  // State register.
  always_ff @(posedge CoreClock or negedge CoreResetN) begin
    if (!CoreResetN) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state: a grant starts the fixed three-cycle sequence.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (grantValid) stateNext = ACCESS;
      ACCESS:  stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Latch the granted transaction; the RAM address/data keep their last
  // in-window values so the RAM side sees no toggling on idle cycles.
  always_ff @(posedge CoreClock or negedge CoreResetN) begin
    if (!CoreResetN) begin
      lastGrant <= 1'b1;
      ownerQ    <= PORT_CORE;
      curWrite  <= 1'b0;
      curErr    <= 1'b0;
      MemAddr   <= '0;
      MemWData  <= '0;
    end else if (state == IDLE && grantValid) begin
      ownerQ   <= grantIdx;
      curWrite <= selWrite;
      curErr   <= selOutOfWindow;
      if (bothReq) begin
        lastGrant <= grantIdx;
      end
      if (!selOutOfWindow) begin
        MemAddr  <= selAddr[AddrWidth-1:0];
        MemWData <= selWData;
      end
    end
  end

  // Outputs decoded from registered state; read data passes through from the
  // RAM, whose output is valid in RESP.
  always_comb begin
    inResp   = (state == RESP);
    MemWrite = (state == ACCESS) & curWrite & ~curErr;
    respData = curWrite ? '0 : (curErr ? ErrData : MemRData);
    P0Ack    = inResp & (ownerQ == PORT_CORE);
    P1Ack    = inResp & (ownerQ == PORT_AUX);
    P0RData  = P0Ack ? respData : '0;
    P1RData  = P1Ack ? respData : '0;
    P0Err    = P0Ack & curErr;
    P1Err    = P1Ack & curErr;
    Owner    = ownerQ;
    DbgState = state;
  end

endmodule
